// File: rtl/clk_cen_rst.sv
// Clock-enable and reset generator: qualifies the PLL lock for LOCK_CYCLES cycles,
// then releases sys_reset and emits phase-aligned enables at 1/4, 1/8 and 1/32 rate.
module clk_cen_rst #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       pause,
  output logic       sys_reset,
  output logic       cen_14,
  output logic       cen_7,
  output logic       cen_cpu,
  output logic       running,
  output logic [1:0] state_dbg
);

  localparam int CNT_W = $clog2(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [4:0]       phase, phase_next;
  logic             sync_meta, locked_s;
  logic             run_next;

  // pll_locked is asynchronous; only locked_s is used past this point
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      locked_s  <= sync_meta;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == CNT_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) state_next = WAIT_LOCK;
      end
      default: state_next = WAIT_LOCK;
    endcase
  end

  // Phase starts at 0 on the release edge so the first enables land on fixed cycles
  always_comb begin
    run_next   = (state_next == RUN);
    phase_next = 5'd0;
    if (run_next && state == RUN) phase_next = phase + 5'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      phase     <= 5'd0;
      sys_reset <= 1'b1;
      cen_14    <= 1'b0;
      cen_7     <= 1'b0;
      cen_cpu   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      phase     <= phase_next;
      sys_reset <= !run_next;
      cen_14    <= run_next && (phase_next[1:0] == 2'd3);
      cen_7     <= run_next && (phase_next[2:0] == 3'd7);
      cen_cpu   <= run_next && (phase_next == 5'd31) && !pause;
    end
  end

  assign running   = !sys_reset;
  assign state_dbg = state;

endmodule

// File: tb/tb_clk_cen_rst.sv
// Bench for clk_cen_rst: directed lock/pause/reset scenarios plus random lock traffic,
// all cycles scored against a streak-count reference model.
module tb_clk_cen_rst;

  localparam int L = 16;

  logic       clk;
  logic       reset, pll_locked, pause;
  logic       sys_reset, cen_14, cen_7, cen_cpu, running;
  logic [1:0] state_dbg;

  clk_cen_rst #(.LOCK_CYCLES(L)) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pause      (pause),
    .sys_reset  (sys_reset),
    .cen_14     (cen_14),
    .cen_7      (cen_7),
    .cen_cpu    (cen_cpu),
    .running    (running),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the system runs once the synchronized lock (the raw flag
  // two edges late, blanked for two edges after reset) has been seen high on
  // L+1 consecutive edges; run_len is the 1-based cycle number within RUN.
  bit pll_at[0:8191];
  int edge_n   = 0;
  int last_rst = 0;
  int streak   = 0;
  int run_len  = 0;

  task automatic model_step(input logic r, input logic p, input logic ps);
    bit seen, run;
    logic [1:0] st;
    edge_n++;
    pll_at[edge_n] = p;
    if (r) begin
      last_rst = edge_n;
      streak   = 0;
      run_len  = 0;
    end else begin
      seen = 1'b0;
      if (edge_n - 2 > last_rst) seen = pll_at[edge_n - 2];
      streak  = seen ? streak + 1 : 0;
      run_len = (streak >= L + 1) ? run_len + 1 : 0;
    end
    run = (run_len > 0);
    st  = run ? 2'd2 : (streak > 0 ? 2'd1 : 2'd0);
    exp_q.push_back({st, !run, run,
                     run && (run_len % 4 == 0),
                     run && (run_len % 8 == 0),
                     run && (run_len % 32 == 0) && !ps});
  endtask

  // driver tasks
  task automatic tick(input logic r, input logic p, input logic ps);
    reset = r; pll_locked = p; pause = ps;
    @(posedge clk);
    model_step(r, p, ps);
    #1;
  endtask

  task automatic wait_release(input int max, input int drop_at, output int rel);
    rel = 0;
    for (int i = 1; i <= max; i++) begin
      tick(1'b0, (i == drop_at) ? 1'b0 : 1'b1, 1'b0);
      if (!sys_reset) begin
        rel = i;
        return;
      end
    end
  endtask

  // Cycles 2..64 of RUN (cycle 1 is the release cycle, scored by the monitor)
  task automatic run_window(input bit use_pause, output int n14, output int n7,
                            output int ncpu, output int first_cpu, output int cpu32,
                            output int cpu64, output int misalign);
    n14 = 0; n7 = 0; ncpu = 0; first_cpu = 0; cpu32 = 0; cpu64 = 0; misalign = 0;
    for (int c = 2; c <= 64; c++) begin
      tick(1'b0, 1'b1, use_pause && c >= 20 && c <= 50);
      n14 += int'(cen_14);
      n7  += int'(cen_7);
      ncpu += int'(cen_cpu);
      if (cen_cpu && first_cpu == 0) first_cpu = c;
      if (c == 32) cpu32 = int'(cen_cpu);
      if (c == 64) cpu64 = int'(cen_cpu);
      if ((cen_cpu && !(cen_7 && cen_14)) || (cen_7 && !cen_14)) misalign++;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", int'({state_dbg, sys_reset, running, cen_14, cen_7, cen_cpu}), int'(e));
    end
  end

  initial begin
    int rel, n14, n7, ncpu, first_cpu, cpu32, cpu64, misalign;
    int drop_left;
    logic p;
    reset = 1'b1; pll_locked = 1'b1; pause = 1'b0;

    // power-on reset with lock already high, then qualification
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    check("reset_sys_reset", int'(sys_reset), 1);
    check("reset_enables", int'({cen_14, cen_7, cen_cpu, running}), 0);
    wait_release(40, 0, rel);
    check("release_after_reset", rel, 19);

    run_window(1'b0, n14, n7, ncpu, first_cpu, cpu32, cpu64, misalign);
    check("run_cen14_count", n14, 16);
    check("run_cen7_count", n7, 8);
    check("run_cpu_count", ncpu, 2);
    check("run_first_cpu", first_cpu, 32);
    check("run_alignment", misalign, 0);

    // reset pulse in the middle of RUN
    tick(1'b1, 1'b1, 1'b0);
    check("midrun_reset_outputs", int'({sys_reset, running, cen_14, cen_7, cen_cpu}), 16);
    check("midrun_reset_state", int'(state_dbg), 0);
    wait_release(40, 0, rel);
    check("release_after_midrun_reset", rel, 19);

    run_window(1'b1, n14, n7, ncpu, first_cpu, cpu32, cpu64, misalign);
    check("pause_cpu_at_32", cpu32, 0);
    check("pause_cpu_at_64", cpu64, 1);
    check("pause_cpu_count", ncpu, 1);
    check("pause_cen14_count", n14, 16);
    check("pause_cen7_count", n7, 8);

    // lock lost in RUN, then relock
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    check("lock_loss_sys_reset", int'(sys_reset), 1);
    check("lock_loss_enables", int'({cen_14, cen_7, cen_cpu, running}), 0);
    wait_release(40, 0, rel);
    check("release_after_relock", rel, 19);

    // one-cycle glitch while the stability count is at 10
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
    wait_release(60, 12, rel);
    check("release_after_glitch", rel, 31);

    // random lock dropouts, pause and occasional reset
    drop_left = 0;
    for (int i = 0; i < 900; i++) begin
      if (drop_left == 0 && $urandom_range(0, 59) == 0) drop_left = $urandom_range(1, 3);
      p = (drop_left == 0);
      if (drop_left > 0) drop_left--;
      tick($urandom_range(0, 299) == 0, p, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
